// File: rtl/countdown_timer.sv
// countdown_timer: loadable 1 Hz seconds countdown with start/pause, done pulse and MM:SS display scan
module countdown_timer #(
  parameter int TICK_CYCLES = 100000000,
  parameter int SCAN_DELAY  = 20000,
  parameter int MAX_SECONDS = 5999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [12:0] load_seconds,
  input  logic        start,
  input  logic        pause,
  output logic [12:0] remaining,
  output logic        running,
  output logic        done,
  output logic [7:0]  tub_segments,
  output logic [3:0]  tub_select
);
  localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = SCAN_DELAY > 1 ? $clog2(SCAN_DELAY) : 1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DELAY - 1);
  localparam logic [12:0]   MAX_S    = 13'(MAX_SECONDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

  state_t          r_state;
  logic [12:0]     r_remaining;
  logic [PW-1:0]   r_presc;
  logic            r_done;
  logic [SW-1:0]   r_scan;
  logic [1:0]      r_idx;
  logic [7:0]      r_seg;
  logic [3:0]      r_sel;

  logic            w_wrap;
  logic [6:0]      w_min;
  logic [5:0]      w_sec;
  logic [3:0]      w_digit;

  assign w_wrap       = r_presc == TICK_MAX;
  assign w_min        = 7'(r_remaining / 13'd60);
  assign w_sec        = 6'(r_remaining % 13'd60);
  assign w_digit      = r_idx == 2'd0 ? 4'(w_min / 7'd10) :
                        r_idx == 2'd1 ? 4'(w_min % 7'd10) :
                        r_idx == 2'd2 ? 4'(w_sec / 6'd10) : 4'(w_sec % 6'd10);
  assign remaining    = r_remaining;
  assign running      = r_state == S_RUN;
  assign done         = r_done;
  assign tub_segments = r_seg;
  assign tub_select   = r_sel;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hFC;
      4'd1:    seg_code = 8'h60;
      4'd2:    seg_code = 8'hDA;
      4'd3:    seg_code = 8'hF2;
      4'd4:    seg_code = 8'h66;
      4'd5:    seg_code = 8'hB6;
      4'd6:    seg_code = 8'hBE;
      4'd7:    seg_code = 8'hE0;
      4'd8:    seg_code = 8'hFE;
      4'd9:    seg_code = 8'hE6;
      default: seg_code = 8'h00;
    endcase
  endfunction

  // Countdown FSM: load beats everything, pause beats start in RUN, a pause on the wrap edge holds the prescaler at its top value
  always_ff @(posedge clk) begin
    r_done <= 1'b0;
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_presc     <= '0;
    end else if (load) begin
      r_state     <= S_IDLE;
      r_remaining <= load_seconds > MAX_S ? MAX_S : load_seconds;
      r_presc     <= '0;
    end else if (r_state == S_RUN) begin
      if (pause) begin
        r_state <= S_PAUSED;
        r_presc <= w_wrap ? r_presc : r_presc + PW'(1);
      end else if (w_wrap) begin
        r_presc <= '0;
        if (r_remaining != 13'd0) r_remaining <= r_remaining - 13'd1;
        if (r_remaining == 13'd1) begin
          r_state <= S_EXPIRED;
          r_done  <= 1'b1;
        end
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end else if (start && r_remaining != 13'd0 && (r_state == S_IDLE || r_state == S_PAUSED)) begin
      r_state <= S_RUN;
    end
  end

  // Display scan: on each scan wrap latch the current digit, then advance the index
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_seg  <= 8'h00;
      r_sel  <= 4'b0000;
    end else if (r_scan == SCAN_MAX) begin
      r_scan <= '0;
      r_idx  <= r_idx + 2'd1;
      r_seg  <= seg_code(w_digit);
      r_sel  <= 4'b1000 >> r_idx;
    end else begin
      r_scan <= r_scan + SW'(1);
    end
  end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable seconds countdown: the down-counting counterpart to the up-counting time-of-day timer. It takes a duration from the mode controller (e.g. a fixed run period for a timed mode), counts it down at 1 Hz with start/pause control, and emits a one-cycle `done` pulse at zero. It also drives its own MM:SS multiplexed seven-segment display, so a mode can show time remaining.

## Interface
- `TICK_CYCLES`, default 100000000: clk cycles per counted second (100 MHz).
- `SCAN_DELAY`, default 20000: clk cycles per display digit step.
- `MAX_SECONDS`, default 5999: load clamp (99:59).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  one-cycle pulse; capture `load_seconds`.
- `load_seconds`  in  13  duration in seconds, unsigned.
- `start`  in  1  one-cycle pulse; begin or resume counting.
- `pause`  in  1  one-cycle pulse; freeze counting.
- `remaining`  out  13  seconds left, registered.
- `running`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when count reaches 0.
- `tub_segments`  out  8  segment code of the selected digit.
- `tub_select`  out  4  one-hot digit select; 4'b1000 is minutes tens, 4'b0001 is seconds units.

## Operation
- States are IDLE, RUN, PAUSED and EXPIRED. `running` is high exactly when the state is RUN.
- **Load** (any state)
  - `remaining` <= min(`load_seconds`, `MAX_SECONDS`).
  - Prescaler cleared; state goes to IDLE.
  - Load beats start and pause in the same cycle.
- **Start**
  - From IDLE or PAUSED with `remaining` > 0: go to RUN. Prescaler is not cleared on resume from PAUSED; it was already cleared by load.
  - Start with `remaining` == 0, in RUN, or in EXPIRED: ignored.
- **RUN**
  - Prescaler counts 0..`TICK_CYCLES`-1 and wraps.
  - On each wrap, `remaining` decrements by 1.
  - If that decrement takes `remaining` from 1 to 0: state goes to EXPIRED and `done` = 1 for that single cycle.
- **Pause**
  - In RUN: go to PAUSED; prescaler holds its value.
  - Pause on the same cycle as a wrap: pause wins; no decrement; prescaler holds at `TICK_CYCLES`-1.
  - Pause outside RUN: ignored.
  - Start and pause in the same cycle in RUN: pause wins. In PAUSED: start wins.
- **EXPIRED**
  - `remaining` stays 0; start and pause are ignored.
  - Only load or reset leaves EXPIRED.
- **Display**
  - Minutes = `remaining` / 60 (0..99); seconds = `remaining` % 60.
  - Digits are minutes tens, minutes units, seconds tens, seconds units.
  - Scan counter counts 0..`SCAN_DELAY`-1. On wrap, the current scan index is shown, then the index advances mod 4.
  - Segment codes follow the codebase encoding, active-high, MSB = a: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=E6.
  - All digits are always shown, with no leading-zero blanking.
- **Arithmetic:** `remaining` never underflows, and a decrement is never applied at 0.

## Timing
- **Reset** forces, at the next edge:
  - state IDLE, `remaining` = 0, prescaler = 0;
  - `running` = 0, `done` = 0;
  - scan counter = 0, scan index = 0;
  - `tub_segments` = 8'h00, `tub_select` = 4'b0000.
- **Reset during RUN** aborts the count with no `done` pulse.
- **Control latency**
  - Load, start and pause are sampled at edge N; `remaining`, `running` and state update at edge N.
  - Start accepted at edge N with prescaler 0: first decrement at edge N+`TICK_CYCLES`, then every `TICK_CYCLES` edges.
- **Expiry:** with L loaded (L ≥ 1) and no pause, `done` rises at edge N+L·`TICK_CYCLES` and falls one edge later.
- **Display:** the first valid `tub_select` appears `SCAN_DELAY` edges after reset release. Display data is `remaining` as sampled at the update edge.

## Test plan
Run with `TICK_CYCLES`=10 and `SCAN_DELAY`=4.
1. Load 3, start at edge 0 -> `remaining` reads 2, 1, 0 at edges 10, 20, 30; `done` high only in the cycle after edge 30; state EXPIRED; `running` = 0.
2. Load 5, start, pause at edge 13, start at edge 20 -> `remaining` = 4 while paused; next decrement at edge 27 (prescaler resumes at 3).
3. Load 6000 -> `remaining` = 5999. Display cycles through E6, E6, B6, E6 with select 1000, 0100, 0010, 0001 (99:59).
4. Load 0, then start -> stays IDLE; `running` = 0; no `done` pulse. Load and start in the same cycle with value 7 -> IDLE with `remaining` = 7.
5. Pause coincident with the wrap edge -> no decrement; state PAUSED. Start in EXPIRED -> ignored.
6. Assert reset mid-RUN at `remaining` = 4 -> next edge shows all outputs zero; `done` never pulses; `tub_select` = 0000 for 4 edges after reset release.
